// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   DEF_WIDTH      = 8;
  localparam int   DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop line synchronizer with falling-edge detect
// All flops reset to the idle-high line level so reset itself never looks like a start edge.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx   = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ready output and error flags
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic             clk_baud,
  input  logic             rst,
  input  logic             rx_in,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic w_rx;
  logic w_fall;

  uart_rx_sync u_sync (
    .i_clk  (clk_baud),
    .i_rst  (rst),
    .i_rx   (rx_in),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

  state_e           r_state, w_state_nxt;
  logic [TW-1:0]    r_tick, w_tick_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_perr_pend, w_perr_pend_nxt;
  logic             w_commit;
  logic             w_ferr_nxt;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_ferr;
  logic             r_ovr;

  logic w_half;
  logic w_full;
  assign w_half = (r_tick == TW'(OVERSAMPLE / 2 - 1));
  assign w_full = (r_tick == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_perr_pend <= w_perr_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick + TW'(1);
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_perr_pend_nxt = r_perr_pend;
    w_commit        = 1'b0;
    w_ferr_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        w_bit_nxt  = '0;
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_half) begin
          w_tick_nxt  = '0;
          w_state_nxt = (w_rx == START_BIT) ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_tick_nxt  = '0;
          w_shift_nxt = (r_shift << 1) | WIDTH'(w_rx);
          if (r_bit == BW'(WIDTH - 1)) begin
            w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_tick_nxt      = '0;
          w_perr_pend_nxt = (^r_shift) ^ w_rx;
          w_state_nxt     = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_tick_nxt  = '0;
          w_commit    = 1'b1;
          w_ferr_nxt  = (w_rx != STOP_BIT);
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_tick_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A commit coinciding with a handshake counts as consumed, so overrun only flags a lost word.
  always_ff @(posedge clk_baud) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_commit) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      r_perr  <= r_perr_pend;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= r_valid & ~rx_ready;
    end else if (r_valid && rx_ready) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule
